// File: rtl/branch_predictor_gshare_if.sv
// Fetch/execute <-> direction predictor bundle.
//   master: drives lookup, update, flush and statistics-clear requests; receives
//           the registered prediction and the statistics counters.
//   slave : the predictor itself.
interface branch_predictor_gshare_if #(
  parameter int unsigned PC_W   = 32,
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned STAT_W = 32
);
  logic              en;
  logic              lookup_valid;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_valid;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_index;
  logic              update_valid;
  logic [IDX_W-1:0]  update_index;
  logic              update_taken;
  logic              update_mispredict;
  logic              flush;
  logic              stats_clr;
  logic [STAT_W-1:0] lookup_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  modport master (
    output en, lookup_valid, lookup_pc, update_valid, update_index, update_taken,
           update_mispredict, flush, stats_clr,
    input  pred_valid, pred_taken, pred_index, lookup_cnt, mispred_cnt
  );

  modport slave (
    input  en, lookup_valid, lookup_pc, update_valid, update_index, update_taken,
           update_mispredict, flush, stats_clr,
    output pred_valid, pred_taken, pred_index, lookup_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// Bimodal / gshare branch direction predictor.
//   clk    : rising-edge clock
//   arst_n : asynchronous active-low reset
//   bus    : slave side of branch_predictor_gshare_if
//            lookup_*  -> registered pred_valid/pred_taken/pred_index one cycle later
//            update_*  -> trains saturating counter at update_index and the history
//            flush     -> clears history, drops a same-cycle lookup
//            stats_*   -> saturating lookup / mispredict counters
module branch_predictor_gshare #(
  parameter int unsigned ENTRIES = 32,
  parameter int unsigned CTR_W   = 2,
  parameter int unsigned GHR_W   = 4,
  parameter int unsigned MODE    = 1,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned STAT_W  = 32
) (
  input logic                    clk,
  input logic                    arst_n,
  branch_predictor_gshare_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(ENTRIES);

  typedef logic [CTR_W-1:0] ctr_t;
  localparam ctr_t CtrWnt = ctr_t'((1 << (CTR_W - 1)) - 1);
  localparam ctr_t CtrMax = {CTR_W{1'b1}};
  localparam logic [STAT_W-1:0] StatMax = {STAT_W{1'b1}};

  ctr_t              ctr_q [ENTRIES];
  ctr_t              ctr_d [ENTRIES];
  logic [GHR_W-1:0]  ghr_q, ghr_d;
  logic              pred_valid_q, pred_valid_d;
  logic              pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0]  pred_index_q, pred_index_d;
  logic [STAT_W-1:0] lookup_cnt_q, lookup_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic             upd, look, do_flush;
  logic [IDX_W-1:0] pc_idx, lookup_idx;
  ctr_t             upd_ctr;

  assign upd      = bus.en & bus.update_valid;
  assign look     = bus.en & bus.lookup_valid & ~bus.flush;
  assign do_flush = bus.en & bus.flush;
  assign pc_idx   = bus.lookup_pc[IDX_W+1:2];
  // Hash uses the history before any same-cycle update.
  assign lookup_idx = pc_idx ^ ((MODE == 1) ? IDX_W'(ghr_q) : '0);
  assign upd_ctr    = ctr_q[bus.update_index];

  logic unused_pc;
  assign unused_pc = ^{bus.lookup_pc[PC_W-1:IDX_W+2], bus.lookup_pc[1:0]};

  always_comb begin
    ctr_d         = ctr_q;
    ghr_d         = ghr_q;
    pred_valid_d  = look;
    pred_taken_d  = pred_taken_q;
    pred_index_d  = pred_index_q;
    lookup_cnt_d  = lookup_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (upd) begin
      if (bus.update_taken) begin
        if (upd_ctr != CtrMax) ctr_d[bus.update_index] = upd_ctr + ctr_t'(1);
      end else begin
        if (upd_ctr != '0) ctr_d[bus.update_index] = upd_ctr - ctr_t'(1);
      end
      // Truncation keeps {ghr[GHR_W-2:0], taken}, also valid for GHR_W == 1.
      ghr_d = GHR_W'({ghr_q, bus.update_taken});
    end
    if (do_flush) ghr_d = '0;

    if (look) begin
      // Reading ctr_d gives the write-to-read bypass for a same-index update.
      pred_taken_d = ctr_d[lookup_idx][CTR_W-1];
      pred_index_d = lookup_idx;
    end

    if (bus.stats_clr) begin
      lookup_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      if (look && lookup_cnt_q != StatMax) lookup_cnt_d = lookup_cnt_q + STAT_W'(1);
      if (upd && bus.update_mispredict && mispred_cnt_q != StatMax) begin
        mispred_cnt_d = mispred_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CtrWnt;
      ghr_q         <= '0;
      pred_valid_q  <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_index_q  <= '0;
      lookup_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      ctr_q         <= ctr_d;
      ghr_q         <= ghr_d;
      pred_valid_q  <= pred_valid_d;
      pred_taken_q  <= pred_taken_d;
      pred_index_q  <= pred_index_d;
      lookup_cnt_q  <= lookup_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.pred_valid  = pred_valid_q;
  assign bus.pred_taken  = pred_taken_q;
  assign bus.pred_index  = pred_index_q;
  assign bus.lookup_cnt  = lookup_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;
endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Two predictors (bimodal and gshare, 4-bit statistics) share one stimulus
// stream; each is checked against directed expectations and a reference model.
module tb_branch_predictor_gshare;
  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
  localparam int STAT_W  = 4;
  localparam int STATMAX = 15;
  localparam int CTRMAX  = 3;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic        en, lv, uv, ut, um, fl, sc;
  logic [31:0] pc;
  logic [4:0]  uidx0, uidx1;

  branch_predictor_gshare_if #(.PC_W(32), .IDX_W(IDX_W), .STAT_W(STAT_W)) bus0 ();
  branch_predictor_gshare_if #(.PC_W(32), .IDX_W(IDX_W), .STAT_W(STAT_W)) bus1 ();

  assign bus0.en = en;  assign bus0.lookup_valid = lv;  assign bus0.lookup_pc = pc;
  assign bus0.update_valid = uv;  assign bus0.update_index = uidx0;
  assign bus0.update_taken = ut;  assign bus0.update_mispredict = um;
  assign bus0.flush = fl;  assign bus0.stats_clr = sc;
  assign bus1.en = en;  assign bus1.lookup_valid = lv;  assign bus1.lookup_pc = pc;
  assign bus1.update_valid = uv;  assign bus1.update_index = uidx1;
  assign bus1.update_taken = ut;  assign bus1.update_mispredict = um;
  assign bus1.flush = fl;  assign bus1.stats_clr = sc;

  branch_predictor_gshare #(.ENTRIES(32), .CTR_W(2), .GHR_W(4), .MODE(0), .PC_W(32),
                            .STAT_W(STAT_W)) dut0 (.clk(clk), .arst_n(arst_n), .bus(bus0));
  branch_predictor_gshare #(.ENTRIES(32), .CTR_W(2), .GHR_W(4), .MODE(1), .PC_W(32),
                            .STAT_W(STAT_W)) dut1 (.clk(clk), .arst_n(arst_n), .bus(bus1));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain integer counters, history as an integer mod 16.
  int m_ctr [2][ENTRIES];
  int m_ghr [2];
  int m_lc [2];
  int m_mc [2];
  bit e_valid [2];
  int e_taken [2];
  int e_index [2];

  function automatic int o_valid(int m); return (m == 0) ? bus0.pred_valid : bus1.pred_valid; endfunction
  function automatic int o_taken(int m); return (m == 0) ? bus0.pred_taken : bus1.pred_taken; endfunction
  function automatic int o_index(int m); return (m == 0) ? bus0.pred_index : bus1.pred_index; endfunction
  function automatic int o_lc(int m); return (m == 0) ? bus0.lookup_cnt : bus1.lookup_cnt; endfunction
  function automatic int o_mc(int m); return (m == 0) ? bus0.mispred_cnt : bus1.mispred_cnt; endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[m][i] = 1;
      m_ghr[m] = 0; m_lc[m] = 0; m_mc[m] = 0;
      e_valid[m] = 0; e_taken[m] = 0; e_index[m] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int m = 0; m < 2; m++) begin
      int hist_before;
      int u;
      int idx;
      hist_before = m_ghr[m];
      u = (m == 0) ? int'(uidx0) : int'(uidx1);
      if (en && uv) begin
        if (ut) m_ctr[m][u] = (m_ctr[m][u] + 1 > CTRMAX) ? CTRMAX : m_ctr[m][u] + 1;
        else    m_ctr[m][u] = (m_ctr[m][u] - 1 < 0) ? 0 : m_ctr[m][u] - 1;
        if (!fl) m_ghr[m] = (m_ghr[m] * 2 + int'(ut)) % 16;
      end
      if (en && fl) m_ghr[m] = 0;
      if (en && lv && !fl) begin
        idx = int'((pc >> 2) % 32) ^ ((m == 1) ? hist_before : 0);
        e_valid[m] = 1;
        e_index[m] = idx;
        e_taken[m] = (m_ctr[m][idx] >= 2) ? 1 : 0;
      end else begin
        e_valid[m] = 0;
      end
      if (sc) begin
        m_lc[m] = 0; m_mc[m] = 0;
      end else begin
        if (en && lv && !fl && m_lc[m] < STATMAX) m_lc[m]++;
        if (en && uv && um && m_mc[m] < STATMAX) m_mc[m]++;
      end
    end
  endfunction

  task automatic idle_inputs();
    en = 1; lv = 0; pc = '0; uv = 0; ut = 0; um = 0; fl = 0; sc = 0; uidx0 = '0; uidx1 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    arst_n = 0;
    model_reset();
    @(posedge clk);
    #1 arst_n = 1;
  endtask

  task automatic do_update(input int idx, input bit t, input bit mp);
    uv = 1; uidx0 = 5'(idx); uidx1 = 5'(idx); ut = t; um = mp;
    step();
    uv = 0; um = 0;
  endtask

  task automatic do_lookup(input logic [31:0] p);
    lv = 1; pc = p;
    step();
    lv = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if ({o_valid(m), o_taken(m), o_index(m), o_lc(m), o_mc(m)} !== 5'd0) begin
        miscompares++;
        $display("FAIL reset_state dut%0d: valid=%0d taken=%0d index=%0h lc=%0d mc=%0d, want all 0",
                 m, o_valid(m), o_taken(m), o_index(m), o_lc(m), o_mc(m));
      end
    end
    do_lookup(32'h40);
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (o_valid(m) !== 1 || o_taken(m) !== 0 || o_index(m) !== 'h10) begin
        miscompares++;
        $display("FAIL reset_lookup dut%0d: valid=%0d taken=%0d index=%0h, want 1 0 10",
                 m, o_valid(m), o_taken(m), o_index(m));
      end
    end
    step();
    vectors++;
    if (o_valid(0) !== 0) begin
      miscompares++;
      $display("FAIL valid_one_cycle: got %0d want 0", o_valid(0));
    end
  endtask

  task automatic test_saturation();
    int want [6] = '{1, 1, 1, 0, 0, 1};
    int ups  [6] = '{3, 5, -1, -2, 1, 1};
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      int n;
      n = (ups[s] < 0) ? -ups[s] : ups[s];
      for (int k = 0; k < n; k++) do_update(5, ups[s] > 0, 0);
      do_lookup(32'h14);
      vectors++;
      if (o_valid(0) !== 1 || o_taken(0) !== want[s] || o_index(0) !== 5) begin
        miscompares++;
        $display("FAIL saturation_%0d: valid=%0d taken=%0d index=%0h, want 1 %0d 5",
                 s, o_valid(0), o_taken(0), o_index(0), want[s]);
      end
    end
  endtask

  task automatic test_gshare();
    apply_reset();
    do_update(0, 1, 0); do_update(0, 1, 0); do_update(0, 0, 0); do_update(0, 1, 0);
    do_lookup(32'h40);
    vectors++;
    if (o_index(1) !== 'h1D || o_valid(1) !== 1) begin
      miscompares++;
      $display("FAIL gshare_index: got %0h want 1d", o_index(1));
    end
    vectors++;
    if (o_index(0) !== 'h10) begin
      miscompares++;
      $display("FAIL bimodal_index: got %0h want 10", o_index(0));
    end
    fl = 1; step(); fl = 0;
    do_lookup(32'h40);
    vectors++;
    if (o_index(1) !== 'h10) begin
      miscompares++;
      $display("FAIL gshare_after_flush: got %0h want 10", o_index(1));
    end
  endtask

  task automatic test_bypass();
    apply_reset();
    uv = 1; uidx0 = 7; uidx1 = 7; ut = 1; lv = 1; pc = 32'h1C;
    step();
    uv = 0; lv = 0;
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if (o_taken(m) !== 1 || o_index(m) !== 7) begin
        miscompares++;
        $display("FAIL bypass dut%0d: taken=%0d index=%0h, want 1 7", m, o_taken(m), o_index(m));
      end
    end
  endtask

  task automatic test_stats();
    apply_reset();
    for (int k = 0; k < 20; k++) do_lookup($urandom);
    vectors++;
    if (o_lc(0) !== 15 || o_lc(1) !== 15) begin
      miscompares++;
      $display("FAIL lookup_cnt_sat: got %0d/%0d want 15", o_lc(0), o_lc(1));
    end
    for (int k = 0; k < 3; k++) do_update(k, 1, 1);
    vectors++;
    if (o_mc(0) !== 3 || o_mc(1) !== 3) begin
      miscompares++;
      $display("FAIL mispred_cnt: got %0d/%0d want 3", o_mc(0), o_mc(1));
    end
    sc = 1; lv = 1; pc = 32'h80;
    step();
    sc = 0; lv = 0;
    vectors++;
    if (o_lc(0) !== 0 || o_mc(0) !== 0) begin
      miscompares++;
      $display("FAIL stats_clr: lc=%0d mc=%0d want 0 0", o_lc(0), o_mc(0));
    end
  endtask

  task automatic test_enable_flush();
    apply_reset();
    en = 0; lv = 1; pc = 32'h0C; uv = 1; uidx0 = 3; uidx1 = 3; ut = 1; um = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      vectors++;
      if (o_valid(0) !== 0 || o_lc(0) !== 0 || o_mc(0) !== 0) begin
        miscompares++;
        $display("FAIL enable_off_%0d: valid=%0d lc=%0d mc=%0d want 0 0 0",
                 k, o_valid(0), o_lc(0), o_mc(0));
      end
    end
    idle_inputs();
    do_lookup(32'h0C);
    vectors++;
    if (o_taken(0) !== 0 || o_index(0) !== 3 || o_index(1) !== 3) begin
      miscompares++;
      $display("FAIL enable_table_hold: taken=%0d idx0=%0h idx1=%0h want 0 3 3",
               o_taken(0), o_index(0), o_index(1));
    end
    fl = 1; lv = 1; pc = 32'h20;
    step();
    fl = 0; lv = 0;
    vectors++;
    if (o_valid(0) !== 0 || o_lc(0) !== 1) begin
      miscompares++;
      $display("FAIL flush_drop: valid=%0d lc=%0d want 0 1", o_valid(0), o_lc(0));
    end
    // Flush with update: counter trains, history does not shift.
    fl = 1; uv = 1; uidx0 = 9; uidx1 = 9; ut = 1;
    step();
    fl = 0; uv = 0;
    do_update(9, 1, 0);
    do_lookup(32'h24);
    vectors++;
    if (o_taken(0) !== 1 || o_index(1) !== 8 || o_taken(1) !== 0) begin
      miscompares++;
      $display("FAIL flush_update: taken0=%0d idx1=%0h taken1=%0d want 1 8 0",
               o_taken(0), o_index(1), o_taken(1));
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    do_update(2, 1, 1); do_update(2, 1, 1);
    lv = 1; pc = 32'h08;
    step();
    idle_inputs();
    #2 arst_n = 0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      vectors++;
      if ({o_valid(m), o_taken(m), o_index(m), o_lc(m), o_mc(m)} !== 5'd0) begin
        miscompares++;
        $display("FAIL async_reset dut%0d: valid=%0d taken=%0d index=%0h lc=%0d mc=%0d want 0",
                 m, o_valid(m), o_taken(m), o_index(m), o_lc(m), o_mc(m));
      end
    end
    #1 arst_n = 1;
    do_lookup(32'h08);
    vectors++;
    if (o_taken(0) !== 0 || o_index(1) !== 2) begin
      miscompares++;
      $display("FAIL async_reset_table: taken=%0d idx1=%0h want 0 2", o_taken(0), o_index(1));
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      en = ($urandom_range(0, 99) < 88);
      lv = $urandom_range(0, 1);
      pc = $urandom;
      uv = $urandom_range(0, 1);
      ut = $urandom_range(0, 1);
      um = $urandom_range(0, 1);
      fl = en && ($urandom_range(0, 99) < 5);
      sc = en && ($urandom_range(0, 99) < 4);
      uidx0 = $urandom_range(0, 1) ? 5'(e_index[0]) : 5'($urandom);
      uidx1 = $urandom_range(0, 1) ? 5'(e_index[1]) : 5'($urandom);
      step();
      for (int m = 0; m < 2; m++) begin
        vectors++;
        if (o_valid(m) !== int'(e_valid[m]) || o_lc(m) !== m_lc[m] || o_mc(m) !== m_mc[m] ||
            (e_valid[m] && (o_taken(m) !== e_taken[m] || o_index(m) !== e_index[m]))) begin
          miscompares++;
          $display("FAIL random_c%0d dut%0d: v/t/i/lc/mc=%0d/%0d/%0h/%0d/%0d want %0d/%0d/%0h/%0d/%0d",
                   c, m, o_valid(m), o_taken(m), o_index(m), o_lc(m), o_mc(m),
                   e_valid[m], e_taken[m], e_index[m], m_lc[m], m_mc[m]);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_saturation();
    test_gshare();
    test_bypass();
    test_stats();
    test_enable_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
